// File: rtl/serial_adder_pkg.sv
// ============================================================================
// serial_adder_pkg : shared state encoding and default width for serial_adder
// Revision 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_fa.sv
// ============================================================================
// serial_adder_fa : full adder built from two half-adder cells and an OR
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  serial_adder_ha u_ha0 (
    .a (a),
    .b (b),
    .s (w_s0),
    .c (w_c0)
  );

  serial_adder_ha u_ha1 (
    .a (w_s0),
    .b (cin),
    .s (s),
    .c (w_c1)
  );

  assign cout = w_c0 | w_c1;

endmodule

`default_nettype wire

// File: rtl/serial_adder_ha.sv
// ============================================================================
// serial_adder_ha : single-bit half adder cell
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_adder_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : bit-serial LSB-first unsigned adder, one bit per clock
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             carry;
  logic [CW-1:0]    count;
  logic             w_s;
  logic             w_c;
  logic             w_load;

  serial_adder_fa u_fa (
    .a    (ra[0]),
    .b    (rb[0]),
    .cin  (carry),
    .s    (w_s),
    .cout (w_c)
  );

  always_comb begin
    state_nxt = state;
    w_load    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SHIFT;
          w_load    = 1'b1;
        end
      end
      S_SHIFT: begin
        if (count == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        // A start in the DONE cycle chains straight into the next add.
        if (start) begin
          state_nxt = S_SHIFT;
          w_load    = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (w_load) begin
        ra    <= a;
        rb    <= b;
        carry <= 1'b0;
        count <= '0;
        sum   <= '0;
        cout  <= 1'b0;
      end else if (state == S_SHIFT) begin
        ra    <= ra >> 1;
        rb    <= rb >> 1;
        sum   <= {w_s, sum[WIDTH-1:1]};
        carry <= w_c;
        count <= count + 1'b1;
        if (count == LAST) cout <= w_c;
      end
    end
  end

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : randomized and directed checks of serial_adder vs a+b
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int W  = 8;
  localparam int W4 = 4;
  localparam int TIMEOUT = 40;

  logic          clk;
  logic          rst;
  logic          start8, start4;
  logic [W-1:0]  a8, b8, sum8;
  logic [W4-1:0] a4, b4, sum4;
  logic          busy8, done8, cout8;
  logic          busy4, done4, cout4;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge; returns just after the accepting edge.
  task automatic launch8(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start8 = 1'b1; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = $urandom; b8 = $urandom;
  endtask

  // Counts edges until done; lat = edges after the start edge.
  task automatic wait_done8(output int lat);
    lat = 0;
    while (done8 !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done8 !== 1'b1) begin
      checks++; errors++;
      $display("FAIL done8_timeout: done=%b after %0d cycles, required 1", done8, lat);
    end
  endtask

  task automatic check_result8(input string name, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] exp;
    exp = {1'b0, x} + {1'b0, y};
    checks++;
    if ({cout8, sum8} !== exp) begin
      errors++;
      $display("FAIL %s: a=%0d b=%0d got cout=%b sum=%0d, required cout=%b sum=%0d",
               name, x, y, cout8, sum8, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start8 = 0; start4 = 0; a8 = 0; b8 = 0; a4 = 0; b4 = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy8, done8, cout8, sum8} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b cout=%b sum=%0d, required all 0",
               busy8, done8, cout8, sum8);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic run_one8(input string name, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    launch8(x, y);
    checks++;
    if (busy8 !== 1'b1) begin
      errors++; $display("FAIL %s_busy: busy=%b, required 1", name, busy8);
    end
    wait_done8(lat);
    checks++;
    if (lat != W || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL %s_latency: done after %0d edges busy=%b, required %0d edges busy=0",
               name, lat, busy8, W);
    end
    check_result8(name, x, y);
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0) begin
      errors++; $display("FAIL %s_pulse: done=%b one cycle later, required 0", name, done8);
    end
    check_result8({name, "_hold"}, x, y);
  endtask

  task automatic test_directed;
    run_one8("add_3_5", 8'd3, 8'd5);
    run_one8("add_255_1", 8'd255, 8'd1);
    run_one8("add_200_100", 8'd200, 8'd100);
    run_one8("add_0_0", 8'd0, 8'd0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++)
      run_one8("add_rand", W'($urandom), W'($urandom));
  endtask

  task automatic test_start_while_busy;
    int lat;
    launch8(8'd3, 8'd5);
    repeat (3) @(posedge clk);
    #1 start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
    @(posedge clk); #1 start8 = 1'b0;
    wait_done8(lat);
    check_result8("start_ignored", 8'd3, 8'd5);
  endtask

  task automatic test_reset_mid;
    int seen;
    int lat;
    launch8(8'd77, 8'd99);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, cout8, sum8} !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b cout=%b sum=%0d, required all 0",
               busy8, done8, cout8, sum8);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_abandon: %0d active cycles after reset, required 0", seen);
    end
    launch8(8'd10, 8'd20);
    wait_done8(lat);
    check_result8("after_reset_10_20", 8'd10, 8'd20);
  endtask

  task automatic test_back_to_back;
    int lat;
    launch8(8'd3, 8'd5);
    wait_done8(lat);
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd9;
    check_result8("b2b_first", 8'd3, 8'd5);
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== '0) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b done=%b sum=%0d, required busy=1 done=0 sum=0",
               busy8, done8, sum8);
    end
    wait_done8(lat);
    checks++;
    if (lat != W) begin
      errors++; $display("FAIL b2b_latency: %0d edges, required %0d", lat, W);
    end
    check_result8("b2b_second", 8'd7, 8'd9);
  endtask

  task automatic test_exhaustive4;
    int bad;
    int lat;
    logic [W4:0] exp;
    bad = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        @(negedge clk);
        start4 = 1'b1; a4 = W4'(x); b4 = W4'(y);
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        while (done4 !== 1'b1 && lat < TIMEOUT) begin
          @(posedge clk); #1;
          lat++;
        end
        exp = W4'(x) + W4'(y) + 5'd0;
        exp = 5'(x + y);
        checks++;
        if (done4 !== 1'b1 || {cout4, sum4} !== exp) begin
          errors++; bad++;
          if (bad <= 5)
            $display("FAIL sweep4: a=%0d b=%0d got done=%b cout=%b sum=%0d, required cout=%b sum=%0d",
                     x, y, done4, cout4, sum4, exp[W4], exp[W4-1:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_exhaustive4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
